// File: rtl/seq_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : seq_event_logger
// Purpose  : Time-stamps detector pulses with a saturating inter-event gap and
//            queues them in a small FIFO. Define SEQ_LOG_STATE_EN to also log
//            the upstream detector state with each entry (adds out_state).
// Revision : 1.0  initial release
// ============================================================================
module seq_event_logger #(
  parameter int GAP_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       det_in,
  input  logic [2:0]                 det_state,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GAP_W-1:0]           out_gap,
`ifdef SEQ_LOG_STATE_EN
  output logic [2:0]                 out_state,
`endif
  output logic [CNT_W-1:0]           total_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef SEQ_LOG_STATE_EN
  localparam int E_W = GAP_W + 3;
`else
  localparam int E_W = GAP_W;
`endif

  localparam logic [GAP_W-1:0] c_GAP_MAX = {GAP_W{1'b1}};
  localparam logic [AW:0]      c_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]      c_ONE     = (AW+1)'(1);

  logic [E_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [E_W-1:0]   r_head;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_total;
  logic             r_overflow;

  logic             w_event;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [GAP_W-1:0] w_gap_sat;
  logic [E_W-1:0]   w_entry;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic [AW:0]      w_level_next;
  logic [E_W-1:0]   w_head_next;

  assign w_event      = ena && det_in;
  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == c_FULL);
  assign w_pop        = !w_empty && out_ready;
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign w_push       = w_event && (!w_full || w_pop);
  assign w_gap_sat    = (r_gap_cnt == c_GAP_MAX) ? c_GAP_MAX : r_gap_cnt + GAP_W'(1);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

`ifdef SEQ_LOG_STATE_EN
  assign w_entry   = {det_state, w_gap_sat};
  assign out_state = r_head[GAP_W +: 3];
`else
  assign w_entry   = w_gap_sat;
  logic  w_unused_det_state;
  assign w_unused_det_state = ^det_state;
`endif

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + c_ONE;
      2'b01:   w_level_next = r_level - c_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // Head register: next oldest entry after a pop, the fresh entry when it
  // lands in an empty FIFO, otherwise the last head is held.
  always_comb begin
    w_head_next = r_head;
    if (w_pop) begin
      if (r_level > c_ONE)
        w_head_next = r_mem[w_rd_ptr_inc];
      else if (w_push)
        w_head_next = w_entry;
    end else if (w_empty && w_push) begin
      w_head_next = w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_gap_cnt  <= '0;
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (ena) begin
        if (det_in) begin
          r_gap_cnt <= '0;
          r_total   <= r_total + CNT_W'(1);
        end else begin
          r_gap_cnt <= w_gap_sat;
        end
      end
      if (w_event && !w_push)
        r_overflow <= 1'b1;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= w_rd_ptr_inc;
      r_level <= w_level_next;
      r_head  <= w_head_next;
    end
  end

  assign out_valid   = !w_empty;
  assign out_gap     = r_head[GAP_W-1:0];
  assign total_count = r_total;
  assign fifo_level  = r_level;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire
